// File: rtl/nfa_char_feeder_if.sv
// Byte-stream input and per-packet result handshake between a packet source and the
// character feeder. The feeder uses the slave view; the packet source uses master.
interface nfa_char_feeder_if;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_sop;
   logic        s_eop;
   logic        res_valid;
   logic        res_ready;
   logic        res_match;
   logic [15:0] res_len;

   modport master (
      output s_valid, s_data, s_sop, s_eop, res_ready,
      input  s_ready, res_valid, res_match, res_len
   );

   modport slave (
      input  s_valid, s_data, s_sop, s_eop, res_ready,
      output s_ready, res_valid, res_match, res_len
   );
endinterface

// File: rtl/nfa_char_feeder.sv
// Feeds a packetised byte stream into an NFA engine as per-class hit vectors, frames each
// packet with a start-of-data pulse, and reports the engine's match flag and byte count.
module nfa_char_feeder #(
   parameter int NCLS      = 34,
   parameter int MATCH_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   nfa_char_feeder_if.slave  bus,
   input  logic              cfg_we,
   input  logic [5:0]        cfg_addr,
   input  logic [7:0]        cfg_lo,
   input  logic [7:0]        cfg_hi,
   input  logic              cfg_nocase,
   output logic              sod,
   output logic              en,
   output logic [NCLS-1:0]   cls,
   input  logic              match_in,
   output logic              err_drop
);
   typedef enum logic [2:0] {IDLE, SOD, DATA, DRAIN, RESULT} state_t;

   localparam logic [2:0] LAT = 3'(MATCH_LAT);

   state_t          state_reg, state_next;
   logic [NCLS-1:0] hit;
   logic [7:0]      swapped;
   logic            s_ready;
   logic            sod_next, en_next, err_next, load_cnt, capture;
   logic [2:0]      cnt_reg;
   logic            res_match_reg;
   logic [15:0]     res_len_reg;

   // Only ASCII letters swap case; every other byte maps to itself.
   always_comb begin
      swapped = bus.s_data;
      if (bus.s_data >= 8'h41 && bus.s_data <= 8'h5A)
         swapped = bus.s_data | 8'h20;
      else if (bus.s_data >= 8'h61 && bus.s_data <= 8'h7A)
         swapped = bus.s_data & 8'hDF;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCLS; gi++) begin : g_cls
         logic [7:0] lo_reg;
         logic [7:0] hi_reg;
         logic       nocase_reg;

         // Reset value lo>hi makes an unprogrammed class never hit.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               lo_reg     <= 8'hFF;
               hi_reg     <= 8'h00;
               nocase_reg <= 1'b0;
            end else if (cfg_we && cfg_addr == 6'(gi)) begin
               lo_reg     <= cfg_lo;
               hi_reg     <= cfg_hi;
               nocase_reg <= cfg_nocase;
            end
         end

         assign hit[gi] = (lo_reg <= bus.s_data && bus.s_data <= hi_reg) ||
                          (nocase_reg && lo_reg <= swapped && swapped <= hi_reg);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      s_ready    = 1'b0;
      sod_next   = 1'b0;
      en_next    = 1'b0;
      err_next   = 1'b0;
      load_cnt   = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            s_ready = !bus.s_sop;
            if (bus.s_valid) begin
               if (bus.s_sop) begin
                  state_next = SOD;
                  sod_next   = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         SOD: begin
            s_ready = 1'b1;
            if (bus.s_valid) begin
               en_next = 1'b1;
               if (bus.s_eop) begin
                  state_next = DRAIN;
                  load_cnt   = 1'b1;
               end else begin
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            s_ready = 1'b1;
            if (bus.s_valid) begin
               en_next  = 1'b1;
               err_next = bus.s_sop;
               if (bus.s_eop) begin
                  state_next = DRAIN;
                  load_cnt   = 1'b1;
               end
            end
         end
         DRAIN: begin
            // The first DRAIN cycle carries the last en; sample MATCH_LAT cycles later.
            if (cnt_reg == 3'd0) begin
               capture    = 1'b1;
               state_next = RESULT;
            end
         end
         RESULT: begin
            if (bus.res_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sod           <= 1'b0;
         en            <= 1'b0;
         cls           <= '0;
         err_drop      <= 1'b0;
         cnt_reg       <= 3'd0;
         res_match_reg <= 1'b0;
         res_len_reg   <= 16'd0;
      end else begin
         sod      <= sod_next;
         en       <= en_next;
         cls      <= en_next ? hit : '0;
         err_drop <= err_next;
         if (sod_next)
            res_len_reg <= 16'd0;
         else if (en_next && res_len_reg != 16'hFFFF)
            res_len_reg <= res_len_reg + 16'd1;
         if (load_cnt)
            cnt_reg <= LAT;
         else if (cnt_reg != 3'd0)
            cnt_reg <= cnt_reg - 3'd1;
         if (capture)
            res_match_reg <= match_in;
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.res_valid = (state_reg == RESULT);
   assign bus.res_match = res_match_reg;
   assign bus.res_len   = res_len_reg;
endmodule

// File: tb/tb_nfa_char_feeder.sv
// Randomized bench for nfa_char_feeder: a class-table model predicts each en cycle's hit
// vector, and per-packet results are predicted from byte counts and sampled match_in.
module tb_nfa_char_feeder;
   localparam int NCLS      = 34;
   localparam int MATCH_LAT = 2;

   typedef struct {
      logic [NCLS-1:0] c;
      bit              first;
      bit              last;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cfg_we = 1'b0;
   logic [5:0]      cfg_addr = '0;
   logic [7:0]      cfg_lo = '0;
   logic [7:0]      cfg_hi = '0;
   logic            cfg_nocase = 1'b0;
   logic            sod, en, err_drop;
   logic [NCLS-1:0] cls;
   logic            match_in = 1'b0;

   nfa_char_feeder_if bus();

   nfa_char_feeder #(.NCLS(NCLS), .MATCH_LAT(MATCH_LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
      .cfg_nocase(cfg_nocase), .sod(sod), .en(en), .cls(cls),
      .match_in(match_in), .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   int   checks = 0, failures = 0;
   int   exp_sod = 0, exp_err = 0, sod_cnt = 0, err_cnt = 0;
   int   ncyc = 0, match_at = -1;
   bit   prev_sod = 1'b0, force_match = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;
   bit   exp_match_q[$];
   logic [7:0] pkt_q[$];
   logic [7:0] m_lo[NCLS];
   logic [7:0] m_hi[NCLS];
   bit         m_nc[NCLS];
   int   sop_at = -1, cfg_at = -1;
   bit   pre_en = 1'b0;
   logic [7:0] pre_b = '0;
   logic [5:0] wa = '0;
   logic [7:0] wl = '0, wh = '0;
   bit         wn = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCLS; k++) begin
         m_lo[k] = 8'hFF;
         m_hi[k] = 8'h00;
         m_nc[k] = 1'b0;
      end
   endtask

   task automatic model_write(input int a, input logic [7:0] lo, input logic [7:0] hi, input bit nc);
      if (a < NCLS) begin
         m_lo[a] = lo;
         m_hi[a] = hi;
         m_nc[a] = nc;
      end
   endtask

   function automatic logic [NCLS-1:0] model_cls(input int b);
      logic [NCLS-1:0] r = '0;
      int sw = b;
      if (b >= 65 && b <= 90) sw = b + 32;
      else if (b >= 97 && b <= 122) sw = b - 32;
      for (int k = 0; k < NCLS; k++) begin
         int lo = int'(m_lo[k]);
         int hi = int'(m_hi[k]);
         r[k] = (lo <= b && b <= hi) || (m_nc[k] && lo <= sw && sw <= hi);
      end
      return r;
   endfunction

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 3))
         0:       return 8'(65 + $urandom_range(0, 25));
         1:       return 8'(97 + $urandom_range(0, 25));
         2:       return 8'(48 + $urandom_range(0, 9));
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Observes engine-side outputs; also drives match_in and records the value the
   // design must capture, MATCH_LAT cycles after each packet's last en.
   always @(negedge clk) begin
      ncyc++;
      if (!rst) begin
         exp_q.delete();
         match_at = -1;
         prev_sod = 1'b0;
      end else begin
         if (en) begin
            if (exp_q.size() == 0) begin
               chk("en_unexpected", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("cls", cls, mon_e.c);
               if (mon_e.first) chk("sod_then_en", prev_sod, 1);
               if (mon_e.last) match_at = ncyc + MATCH_LAT;
            end
         end else begin
            chk("cls_quiet", cls, 0);
         end
         if (sod) sod_cnt++;
         if (err_drop) err_cnt++;
         prev_sod = sod;
         match_in = force_match ? 1'b1 : 1'($urandom_range(0, 1));
         if (ncyc == match_at) begin
            exp_match_q.push_back(match_in);
            chk("drain_no_result", bus.res_valid, 0);
         end
         if (ncyc == match_at + 1) chk("result_latency", bus.res_valid, 1);
      end
   end

   task automatic cfg_write(input int a, input logic [7:0] lo, input logic [7:0] hi, input bit nc);
      cfg_we = 1'b1; cfg_addr = 6'(a); cfg_lo = lo; cfg_hi = hi; cfg_nocase = nc;
      @(negedge clk);
      cfg_we = 1'b0;
      model_write(a, lo, hi, nc);
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send_byte(input logic [7:0] b, input bit sop, input bit eop,
                            input bit first, input bit last, input bit wr);
      int   guard = 0;
      exp_t e;
      bus.s_valid = 1'b1; bus.s_data = b; bus.s_sop = sop; bus.s_eop = eop;
      #1;
      if (first) chk("idle_sop_not_ready", bus.s_ready, 0);
      while (!bus.s_ready && guard < 20) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!bus.s_ready) begin
         chk("s_ready_timeout", 0, 1);
      end else begin
         e.c = model_cls(int'(b)); e.first = first; e.last = last;
         exp_q.push_back(e);
         if (wr) begin
            cfg_we = 1'b1; cfg_addr = wa; cfg_lo = wl; cfg_hi = wh; cfg_nocase = wn;
            model_write(int'(wa), wl, wh, wn);
         end
      end
      @(negedge clk);
      bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic take_result(input int exp_len, input int hold);
      int guard = 0;
      #1;
      chk("drain_not_ready", bus.s_ready, 0);
      while (!bus.res_valid && guard < 40) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!bus.res_valid) begin
         chk("res_valid_timeout", 0, 1);
         return;
      end
      if (pre_en) begin
         bus.s_valid = 1'b1; bus.s_data = pre_b; bus.s_sop = 1'b1; bus.s_eop = 1'b0;
      end
      for (int i = 0; i < hold; i++) begin
         #1;
         chk("hold_res_valid", bus.res_valid, 1);
         chk("hold_res_len", bus.res_len, exp_len);
         chk("hold_s_ready", bus.s_ready, 0);
         chk("hold_no_sod", sod, 0);
         @(negedge clk);
      end
      #1;
      chk("res_len", bus.res_len, exp_len);
      if (exp_match_q.size() == 0) chk("match_sampled", 0, 1);
      else chk("res_match", bus.res_match, exp_match_q.pop_front());
      $display("pkt len=%0d res_len=%0d res_match=%0b hold=%0d", exp_len, bus.res_len, bus.res_match, hold);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      #1;
      chk("res_valid_clear", bus.res_valid, 0);
   endtask

   task automatic send_packet(input int hold, input bit gaps);
      int n = pkt_q.size();
      exp_sod++;
      for (int i = 0; i < n; i++) begin
         send_byte(pkt_q[i], (i == 0) || (i == sop_at), i == n - 1, i == 0, i == n - 1, i == cfg_at);
         if (i == sop_at && i != 0) exp_err++;
         if (gaps && i != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      take_result((n > 65535) ? 65535 : n, hold);
      sop_at = -1; cfg_at = -1; pre_en = 1'b0;
   endtask

   initial begin
      bus.s_valid = 1'b0; bus.s_data = '0; bus.s_sop = 1'b0; bus.s_eop = 1'b0;
      bus.res_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_sod", sod, 0);
      chk("rst_en", en, 0);
      chk("rst_cls", cls, 0);
      chk("rst_err", err_drop, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_len", bus.res_len, 0);
      chk("rst_res_match", bus.res_match, 0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_ready", bus.s_ready, 1);
      @(negedge clk);

      // Single-byte packet hitting a case-insensitive class.
      cfg_write(0, 8'h61, 8'h61, 1'b1);
      pkt_q = '{8'h41};
      send_packet(0, 0);

      // Digit class at the top index, match_in held high.
      cfg_write(33, 8'h30, 8'h39, 1'b0);
      cfg_write(40, 8'h00, 8'hFF, 1'b1);
      force_match = 1'b1;
      pkt_q = '{8'h78, 8'h35};
      send_packet(0, 0);
      force_match = 1'b0;

      // Non-sop byte in IDLE is discarded.
      bus.s_valid = 1'b1; bus.s_data = 8'h41; bus.s_sop = 1'b0; bus.s_eop = 1'b0;
      #1;
      chk("idle_ready_nonsop", bus.s_ready, 1);
      @(negedge clk);
      bus.s_valid = 1'b0;
      #1;
      chk("drop_err_pulse", err_drop, 1);
      chk("drop_no_en", en, 0);
      chk("drop_no_sod", sod, 0);
      exp_err++;
      @(negedge clk);
      #1;
      chk("drop_err_clear", err_drop, 0);
      @(negedge clk);

      // Result held back while the next packet's sop waits.
      pre_en = 1'b1; pre_b = 8'h5A;
      pkt_q = '{8'h41, 8'h42};
      send_packet(10, 0);
      pkt_q = '{8'h5A, 8'h61};
      send_packet(0, 0);

      // Class write coinciding with a byte accept, plus an sop inside DATA.
      cfg_at = 1; wa = 6'd0; wl = 8'h62; wh = 8'h62; wn = 1'b0;
      sop_at = 2;
      pkt_q = '{8'h62, 8'h62, 8'h62, 8'h62};
      send_packet(1, 0);

      // Reset in the middle of a packet.
      exp_sod++;
      send_byte(8'h31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      send_byte(8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_byte(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_sod", sod, 0);
      chk("mid_rst_en", en, 0);
      chk("mid_rst_cls", cls, 0);
      chk("mid_rst_res_valid", bus.res_valid, 0);
      chk("mid_rst_res_len", bus.res_len, 0);
      model_reset();
      exp_match_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("post_rst_no_result", bus.res_valid, 0);
      end
      pkt_q = '{8'h61, 8'h41, 8'h35, 8'h62};
      send_packet(0, 1);

      // Random class tables and packets.
      for (int i = 0; i < 12; i++) begin
         int lo = $urandom_range(32, 122);
         cfg_write($urandom_range(0, NCLS - 1), 8'(lo), 8'(lo + $urandom_range(0, 24) - 3),
                   1'($urandom_range(0, 1)));
      end
      for (int p = 0; p < 25; p++) begin
         int n = $urandom_range(1, 8);
         pkt_q.delete();
         for (int i = 0; i < n; i++) pkt_q.push_back(rand_byte());
         if ($urandom_range(0, 3) == 0) begin
            cfg_at = $urandom_range(0, n - 1);
            wa = 6'($urandom_range(0, 40));
            wl = 8'($urandom_range(40, 122));
            wh = 8'(int'(wl) + $urandom_range(0, 25) - 2);
            wn = 1'($urandom_range(0, 1));
         end
         if (n > 1 && $urandom_range(0, 4) == 0) sop_at = $urandom_range(1, n - 1);
         send_packet($urandom_range(0, 3), 1);
      end

      // Byte count saturation.
      pkt_q.delete();
      for (int i = 0; i < 65537; i++) pkt_q.push_back(8'h35);
      send_packet(0, 0);

      repeat (3) @(negedge clk);
      chk("sod_count", sod_cnt, exp_sod);
      chk("err_count", err_cnt, exp_err);
      chk("pending_en", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
